vpu_exec_unit: RTL and testbench

- Clocked, parametrised execute unit for the VPU.
- Accepts one 32-bit instruction at a time over a valid/ready handshake and executes it against an internal register file of 32 x DATA_W.
- Keeps the existing opcode encoding and field layout, adds logic ops and NZCV flags, and uses a multi-cycle shift-add multiplier whose high half goes to SGPR.
- Sits between the instruction fetch/sequencer and the debug/trace logic.

---
 rtl/vpu_pkg.sv | 44 ++++
 rtl/vpu_seq_mul.sv | 66 ++++++
 rtl/vpu_exec_unit.sv | 154 +++++++++++++++
 tb/tb_vpu_exec_unit.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpu_pkg.sv
// Shared definitions for the VPU execute unit: opcodes, instruction field
// positions, FSM states and NZCV flag packing.
package vpu_pkg;

  localparam logic [4:0] OP_MOVSGPR = 5'd0;
  localparam logic [4:0] OP_MOV     = 5'd1;
  localparam logic [4:0] OP_ADD     = 5'd2;
  localparam logic [4:0] OP_SUB     = 5'd3;
  localparam logic [4:0] OP_MUL     = 5'd4;
  localparam logic [4:0] OP_AND     = 5'd5;
  localparam logic [4:0] OP_OR      = 5'd6;
  localparam logic [4:0] OP_XOR     = 5'd7;

  localparam int OP_HI        = 31;
  localparam int OP_LO        = 27;
  localparam int RDST_HI      = 26;
  localparam int RDST_LO      = 22;
  localparam int RSRC1_HI     = 21;
  localparam int RSRC1_LO     = 17;
  localparam int IMM_MODE_BIT = 16;
  localparam int RSRC2_HI     = 15;
  localparam int RSRC2_LO     = 11;
  localparam int IMM_HI       = 15;
  localparam int IMM_LO       = 0;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {IDLE, MUL} state_e;

  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/vpu_seq_mul.sv
// Sequential shift-add multiplier, one partial product per cycle.
// done_pulse and product describe the final step while it is being taken.
module vpu_seq_mul #(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     op_a,
  input  logic [DATA_W-1:0]     op_b,
  output logic                  busy,
  output logic                  done_pulse,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic [2*DATA_W-1:0] acc_q, acc_d, mcand_q, mcand_d, step_sum;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                busy_q, busy_d;

  assign step_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign busy       = busy_q;
  assign done_pulse = busy_q && (count_q == LAST);
  assign product    = step_sum;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    busy_d   = busy_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = {{DATA_W{1'b0}}, op_a};
      mplier_d = op_b;
      count_d  = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = step_sum;
      mcand_d  = {mcand_q[2*DATA_W-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[DATA_W-1:1]};
      count_d  = count_q + 1'b1;
      if (count_q == LAST) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/vpu_exec_unit.sv
// VPU execute unit: 32-entry register file, single-cycle ALU with NZCV flags,
// and a multi-cycle multiply whose high half lands in SGPR.
module vpu_exec_unit
  import vpu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int NUM_GPR = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic              done,
  output logic              illegal,
  output logic              busy,
  output logic [3:0]        flags,
  output logic [DATA_W-1:0] sgpr,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] gpr_q [NUM_GPR];
  logic [DATA_W-1:0] gpr_d [NUM_GPR];
  logic [DATA_W-1:0] sgpr_q, sgpr_d;
  logic [3:0]        flags_q, flags_d;
  state_e            state_q, state_d;
  logic [4:0]        mul_rdst_q, mul_rdst_d;
  logic              done_q, done_d, illegal_q, illegal_d;

  logic [4:0]          op, rdst, rsrc1, rsrc2;
  logic                imm_mode, accept, mul_start, mul_busy, mul_last;
  logic [DATA_W-1:0]   imm_ext, opa, opb, logic_res, mul_lo, mul_hi;
  logic [DATA_W:0]     add_sum, sub_sum;
  logic [2*DATA_W-1:0] mul_product;

  assign op       = instr[OP_HI:OP_LO];
  assign rdst     = instr[RDST_HI:RDST_LO];
  assign rsrc1    = instr[RSRC1_HI:RSRC1_LO];
  assign rsrc2    = instr[RSRC2_HI:RSRC2_LO];
  assign imm_mode = instr[IMM_MODE_BIT];
  assign imm_ext  = DATA_W'(instr[IMM_HI:IMM_LO]);

  // Operands come from the current register state, so rdst may equal a source.
  assign opa     = gpr_q[rsrc1];
  assign opb     = imm_mode ? imm_ext : gpr_q[rsrc2];
  assign add_sum = {1'b0, opa} + {1'b0, opb};
  assign sub_sum = {1'b0, opa} + {1'b0, ~opb} + (DATA_W+1)'(1);

  assign instr_ready = (state_q == IDLE) && !rst;
  assign accept      = instr_valid && instr_ready;
  assign mul_start   = accept && (op == OP_MUL);
  assign mul_lo      = mul_product[DATA_W-1:0];
  assign mul_hi      = mul_product[2*DATA_W-1:DATA_W];

  assign done     = done_q;
  assign illegal  = illegal_q;
  assign busy     = mul_busy;
  assign flags    = flags_q;
  assign sgpr     = sgpr_q;
  assign dbg_data = gpr_q[dbg_addr];

  vpu_seq_mul #(.DATA_W(DATA_W)) u_mul (
    .clk        (clk),
    .rst        (rst),
    .start      (mul_start),
    .op_a       (opa),
    .op_b       (opb),
    .busy       (mul_busy),
    .done_pulse (mul_last),
    .product    (mul_product)
  );

  always_comb begin
    logic_res = opa ^ opb;
    case (op)
      OP_AND:  logic_res = opa & opb;
      OP_OR:   logic_res = opa | opb;
      default: ;
    endcase
  end

  always_comb begin
    gpr_d      = gpr_q;
    sgpr_d     = sgpr_q;
    flags_d    = flags_q;
    state_d    = state_q;
    mul_rdst_d = mul_rdst_q;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        done_d = 1'b1;
        case (op)
          OP_MOVSGPR: gpr_d[rdst] = sgpr_q;
          OP_MOV:     gpr_d[rdst] = imm_mode ? imm_ext : opa;
          OP_ADD: begin
            gpr_d[rdst] = add_sum[DATA_W-1:0];
            flags_d = pack_flags(add_sum[DATA_W-1], add_sum[DATA_W-1:0] == '0,
                                 add_sum[DATA_W],
                                 (opa[DATA_W-1] == opb[DATA_W-1]) &&
                                 (add_sum[DATA_W-1] != opa[DATA_W-1]));
          end
          OP_SUB: begin
            gpr_d[rdst] = sub_sum[DATA_W-1:0];
            flags_d = pack_flags(sub_sum[DATA_W-1], sub_sum[DATA_W-1:0] == '0,
                                 sub_sum[DATA_W],
                                 (opa[DATA_W-1] != opb[DATA_W-1]) &&
                                 (sub_sum[DATA_W-1] != opa[DATA_W-1]));
          end
          OP_MUL: begin
            done_d     = 1'b0;
            mul_rdst_d = rdst;
            state_d    = MUL;
          end
          OP_AND, OP_OR, OP_XOR: begin
            gpr_d[rdst] = logic_res;
            flags_d = pack_flags(logic_res[DATA_W-1], logic_res == '0, 1'b0, 1'b0);
          end
          default: illegal_d = 1'b1;
        endcase
      end
      MUL: if (mul_last) begin
        gpr_d[mul_rdst_q] = mul_lo;
        sgpr_d  = mul_hi;
        flags_d = pack_flags(mul_lo[DATA_W-1], mul_product == '0,
                             mul_hi != '0, mul_hi != '0);
        done_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= '0;
      sgpr_q     <= '0;
      flags_q    <= '0;
      state_q    <= IDLE;
      mul_rdst_q <= '0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      gpr_q      <= gpr_d;
      sgpr_q     <= sgpr_d;
      flags_q    <= flags_d;
      state_q    <= state_d;
      mul_rdst_q <= mul_rdst_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
    end
  end

endmodule

// File: tb/tb_vpu_exec_unit.sv
// Self-checking bench for vpu_exec_unit (DATA_W=16) against an arithmetic
// reference model of the instruction set.
module tb_vpu_exec_unit;

  localparam int     W    = 16;
  localparam longint FULL = longint'(1) << W;
  localparam longint HALF = longint'(1) << (W - 1);

  logic         clk, rst, instr_valid, instr_ready, done, illegal, busy;
  logic [31:0]  instr;
  logic [3:0]   flags;
  logic [W-1:0] sgpr, dbg_data;
  logic [4:0]   dbg_addr;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [W-1:0] m_gpr [32];
  logic [W-1:0] m_sgpr;
  logic [3:0]   m_flags;

  vpu_exec_unit #(.DATA_W(W), .NUM_GPR(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .done        (done),
    .illegal     (illegal),
    .busy        (busy),
    .flags       (flags),
    .sgpr        (sgpr),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input int op, input int rd, input int rs1, input int rs2);
    return {5'(op), 5'(rd), 5'(rs1), 1'b0, 5'(rs2), 11'b0};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rd, input int rs1, input int imm);
    return {5'(op), 5'(rd), 5'(rs1), 1'b1, 16'(imm)};
  endfunction

  function automatic longint to_signed(input longint x);
    return (x >= HALF) ? x - FULL : x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_gpr[i] = '0;
    m_sgpr  = '0;
    m_flags = '0;
  endtask

  // Architectural effect of one instruction, from the instruction set rules.
  task automatic model_exec(input logic [31:0] ins);
    int op, rd, rs1, rs2;
    bit im, n, z, c, v;
    longint a, b, res, sres, p, hi;
    op  = int'(ins[31:27]);
    rd  = int'(ins[26:22]);
    rs1 = int'(ins[21:17]);
    im  = ins[16];
    rs2 = int'(ins[15:11]);
    a   = longint'(m_gpr[rs1]);
    b   = im ? longint'(ins[15:0]) : longint'(m_gpr[rs2]);
    case (op)
      0: m_gpr[rd] = m_sgpr;
      1: m_gpr[rd] = W'(im ? b : a);
      2, 3: begin
        if (op == 2) begin
          res  = a + b;
          c    = res >= FULL;
          sres = to_signed(a) + to_signed(b);
        end else begin
          res  = a - b + FULL;
          c    = a >= b;
          sres = to_signed(a) - to_signed(b);
        end
        res = res % FULL;
        v = (sres > HALF - 1) || (sres < -HALF);
        n = res >= HALF;
        z = res == 0;
        m_gpr[rd] = W'(res);
        m_flags = {n, z, c, v};
      end
      4: begin
        p  = a * b;
        hi = p / FULL;
        res = p % FULL;
        m_gpr[rd] = W'(res);
        m_sgpr = W'(hi);
        m_flags = {res >= HALF, p == 0, hi != 0, hi != 0};
      end
      5, 6, 7: begin
        res = (op == 5) ? (a & b) : (op == 6) ? (a | b) : (a ^ b);
        m_gpr[rd] = W'(res);
        m_flags = {res >= HALF, res == 0, 1'b0, 1'b0};
      end
      default: ;
    endcase
  endtask

  // Issues one instruction and waits (bounded) for its retirement.
  task automatic send(input logic [31:0] ins, output int lat, output int rdy_low, output logic ill);
    int w;
    w = 0;
    @(negedge clk);
    while (instr_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    model_exec(ins);
    instr = ins;
    instr_valid = 1'b1;
    lat = -1;
    rdy_low = 0;
    ill = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      instr_valid = 1'b0;
      if (instr_ready !== 1'b1) rdy_low++;
      if (done === 1'b1) begin
        lat = i;
        ill = illegal;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (instr_ready !== 1'b0) $display("[TB] FAIL reset_ready_in_rst: got %b expected 0", instr_ready); else pass_cnt++;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    total_cnt++; if (instr_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", instr_ready); else pass_cnt++;
    total_cnt++; if ({done, illegal, busy} !== 3'b000) $display("[TB] FAIL reset_pulses: got %b expected 000", {done, illegal, busy}); else pass_cnt++;
    total_cnt++; if (flags !== 4'h0) $display("[TB] FAIL reset_flags: got %h expected 0", flags); else pass_cnt++;
    total_cnt++; if (sgpr !== '0) $display("[TB] FAIL reset_sgpr: got %h expected 0", sgpr); else pass_cnt++;
    bad = 0;
    for (int r = 0; r < 32; r++) begin
      dbg_addr = 5'(r);
      #1;
      if (dbg_data !== '0) bad++;
    end
    total_cnt++; if (bad != 0) $display("[TB] FAIL reset_gprs: got %0d nonzero registers expected 0", bad); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    instr = enc_i(1, 1, 0, 5);
    model_exec(instr);
    instr_valid = 1'b1;
    @(negedge clk);
    total_cnt++; if (done !== 1'b1) $display("[TB] FAIL b2b_mov_done: got %b expected 1", done); else pass_cnt++;
    total_cnt++; if (instr_ready !== 1'b1) $display("[TB] FAIL b2b_ready: got %b expected 1", instr_ready); else pass_cnt++;
    instr = enc_i(2, 2, 1, 3);
    model_exec(instr);
    @(negedge clk);
    total_cnt++; if (done !== 1'b1) $display("[TB] FAIL b2b_add_done: got %b expected 1", done); else pass_cnt++;
    instr_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (done !== 1'b0) $display("[TB] FAIL b2b_done_pulse: got %b expected 0", done); else pass_cnt++;
    dbg_addr = 5'd2;
    #1;
    total_cnt++; if (dbg_data !== 16'h0008) $display("[TB] FAIL b2b_r2: got %h expected 0008", dbg_data); else pass_cnt++;
    total_cnt++; if (flags !== 4'b0000) $display("[TB] FAIL b2b_flags: got %b expected 0000", flags); else pass_cnt++;
  endtask

  task automatic test_add_flags();
    logic [31:0] t_ins [7];
    logic [4:0]  t_rd  [7];
    logic [15:0] t_val [7];
    logic [3:0]  t_flg [7];
    int lat, rl;
    logic ill;
    t_ins[0] = enc_i(1, 1, 0, 'h7FFF); t_rd[0] = 1; t_val[0] = 16'h7FFF; t_flg[0] = 4'b0000;
    t_ins[1] = enc_i(2, 3, 1, 1);      t_rd[1] = 3; t_val[1] = 16'h8000; t_flg[1] = 4'b1001;
    t_ins[2] = enc_i(1, 1, 0, 'hFFFF); t_rd[2] = 1; t_val[2] = 16'hFFFF; t_flg[2] = 4'b1001;
    t_ins[3] = enc_i(2, 3, 1, 1);      t_rd[3] = 3; t_val[3] = 16'h0000; t_flg[3] = 4'b0110;
    t_ins[4] = enc_r(3, 4, 1, 1);      t_rd[4] = 4; t_val[4] = 16'h0000; t_flg[4] = 4'b0110;
    t_ins[5] = enc_i(3, 5, 0, 1);      t_rd[5] = 5; t_val[5] = 16'hFFFF; t_flg[5] = 4'b1000;
    t_ins[6] = enc_r(2, 6, 3, 3);      t_rd[6] = 6; t_val[6] = 16'h0000; t_flg[6] = 4'b0111;
    for (int k = 0; k < 7; k++) begin
      if (k == 6) begin
        send(enc_i(1, 3, 0, 'h8000), lat, rl, ill);
      end
      send(t_ins[k], lat, rl, ill);
      dbg_addr = t_rd[k];
      #1;
      total_cnt++; if (lat != 1) $display("[TB] FAIL arith_latency[%0d]: got %0d expected 1", k, lat); else pass_cnt++;
      total_cnt++; if (dbg_data !== t_val[k]) $display("[TB] FAIL arith_value[%0d]: got %h expected %h", k, dbg_data, t_val[k]); else pass_cnt++;
      total_cnt++; if (flags !== t_flg[k]) $display("[TB] FAIL arith_flags[%0d]: got %b expected %b", k, flags, t_flg[k]); else pass_cnt++;
    end
  endtask

  task automatic test_mul();
    int lat, rl;
    logic ill;
    send(enc_i(1, 1, 0, 'h1234), lat, rl, ill);
    send(enc_i(1, 2, 0, 'h0100), lat, rl, ill);
    send(enc_r(4, 5, 1, 2), lat, rl, ill);
    dbg_addr = 5'd5;
    #1;
    total_cnt++; if (lat != 17) $display("[TB] FAIL mul_latency: got %0d expected 17", lat); else pass_cnt++;
    total_cnt++; if (rl != 16) $display("[TB] FAIL mul_ready_low_cycles: got %0d expected 16", rl); else pass_cnt++;
    total_cnt++; if (dbg_data !== 16'h3400) $display("[TB] FAIL mul_lo: got %h expected 3400", dbg_data); else pass_cnt++;
    total_cnt++; if (sgpr !== 16'h0012) $display("[TB] FAIL mul_sgpr: got %h expected 0012", sgpr); else pass_cnt++;
    total_cnt++; if (flags !== 4'b0011) $display("[TB] FAIL mul_flags: got %b expected 0011", flags); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL mul_busy_after: got %b expected 0", busy); else pass_cnt++;
    send(enc_r(0, 6, 0, 0), lat, rl, ill);
    dbg_addr = 5'd6;
    #1;
    total_cnt++; if (dbg_data !== 16'h0012) $display("[TB] FAIL movsgpr_r6: got %h expected 0012", dbg_data); else pass_cnt++;
    send(enc_i(4, 9, 1, 3), lat, rl, ill);
    dbg_addr = 5'd9;
    #1;
    total_cnt++; if (dbg_data !== 16'h369C) $display("[TB] FAIL mul_imm_lo: got %h expected 369c", dbg_data); else pass_cnt++;
    total_cnt++; if ({sgpr, flags} !== {16'h0000, 4'b0000}) $display("[TB] FAIL mul_imm_sgpr_flags: got %h/%b expected 0000/0000", sgpr, flags); else pass_cnt++;
  endtask

  task automatic test_mul_hold();
    logic [31:0]  mul_i, mov_i;
    logic [W-1:0] old7;
    int first_done, second_done, bad;
    mul_i = enc_r(4, 7, 1, 2);
    mov_i = enc_i(1, 8, 0, 'hBEEF);
    old7 = m_gpr[7];
    model_exec(mul_i);
    model_exec(mov_i);
    dbg_addr = 5'd7;
    @(negedge clk);
    instr = mul_i;
    instr_valid = 1'b1;
    first_done = 0;
    second_done = 0;
    bad = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 1) instr = mov_i;
      if (done === 1'b1) begin
        if (first_done == 0) first_done = i;
        else if (second_done == 0) second_done = i;
      end
      if (first_done == 0 && dbg_data !== old7) bad++;
      if (first_done != 0 && i == first_done + 1) instr_valid = 1'b0;
      if (second_done != 0) break;
    end
    instr_valid = 1'b0;
    total_cnt++; if (first_done != 17) $display("[TB] FAIL hold_mul_done: got %0d expected 17", first_done); else pass_cnt++;
    total_cnt++; if (second_done != 18) $display("[TB] FAIL hold_mov_done: got %0d expected 18", second_done); else pass_cnt++;
    total_cnt++; if (bad != 0) $display("[TB] FAIL hold_dbg_early_change: got %0d cycles expected 0", bad); else pass_cnt++;
    #1;
    total_cnt++; if (dbg_data !== m_gpr[7]) $display("[TB] FAIL hold_r7: got %h expected %h", dbg_data, m_gpr[7]); else pass_cnt++;
    dbg_addr = 5'd8;
    #1;
    total_cnt++; if (dbg_data !== 16'hBEEF) $display("[TB] FAIL hold_r8: got %h expected beef", dbg_data); else pass_cnt++;
  endtask

  task automatic test_illegal();
    logic [31:0] ins;
    int lat, rl, bad;
    logic ill;
    for (int k = 0; k < 3; k++) begin
      ins = {5'(k == 0 ? 31 : $urandom_range(8, 31)), 27'($urandom)};
      send(ins, lat, rl, ill);
      total_cnt++; if (lat != 1 || ill !== 1'b1) $display("[TB] FAIL illegal_pulse[%0d]: got lat %0d ill %b expected 1 1", k, lat, ill); else pass_cnt++;
      total_cnt++; if ({flags, sgpr} !== {m_flags, m_sgpr}) $display("[TB] FAIL illegal_state[%0d]: got %b/%h expected %b/%h", k, flags, sgpr, m_flags, m_sgpr); else pass_cnt++;
      bad = 0;
      for (int r = 0; r < 32; r++) begin
        dbg_addr = 5'(r);
        #1;
        if (dbg_data !== m_gpr[r]) bad++;
      end
      total_cnt++; if (bad != 0) $display("[TB] FAIL illegal_gprs[%0d]: got %0d changed expected 0", k, bad); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if ({done, illegal} !== 2'b00) $display("[TB] FAIL illegal_one_cycle[%0d]: got %b expected 00", k, {done, illegal}); else pass_cnt++;
    end
  endtask

  task automatic test_reset_during_mul();
    int done_seen;
    done_seen = 0;
    @(negedge clk);
    instr = enc_r(4, 5, 1, 2);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    if (done === 1'b1) done_seen++;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    total_cnt++; if (instr_ready !== 1'b1) $display("[TB] FAIL rstmul_ready: got %b expected 1", instr_ready); else pass_cnt++;
    repeat (20) begin
      if (done === 1'b1) done_seen++;
      @(negedge clk);
    end
    dbg_addr = 5'd5;
    #1;
    total_cnt++; if (done_seen != 0) $display("[TB] FAIL rstmul_no_done: got %0d pulses expected 0", done_seen); else pass_cnt++;
    total_cnt++; if (dbg_data !== '0) $display("[TB] FAIL rstmul_r5: got %h expected 0", dbg_data); else pass_cnt++;
    total_cnt++; if (sgpr !== '0) $display("[TB] FAIL rstmul_sgpr: got %h expected 0", sgpr); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL rstmul_busy: got %b expected 0", busy); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] ins;
    int op, rd, rs1, rs2, im, imm, sel, lat, rl, exp_lat;
    logic ill, exp_ill;
    for (int r = 0; r < 8; r++) send(enc_i(1, r, 0, $urandom_range(0, 65535)), lat, rl, ill);
    for (int k = 0; k < 60; k++) begin
      op  = $urandom_range(0, 8);
      if (op == 8) op = $urandom_range(8, 31);
      rd  = $urandom_range(0, 7);
      rs1 = $urandom_range(0, 7);
      rs2 = $urandom_range(0, 7);
      im  = $urandom_range(0, 1);
      sel = $urandom_range(0, 5);
      imm = (sel == 0) ? 0 : (sel == 1) ? 1 : (sel == 2) ? 'h7FFF :
            (sel == 3) ? 'h8000 : (sel == 4) ? 'hFFFF : $urandom_range(0, 65535);
      ins = (im != 0) ? enc_i(op, rd, rs1, imm) : enc_r(op, rd, rs1, rs2);
      exp_ill = op > 7;
      exp_lat = (op == 4) ? 17 : 1;
      send(ins, lat, rl, ill);
      dbg_addr = 5'(rd);
      #1;
      total_cnt++; if (lat != exp_lat || ill !== exp_ill) $display("[TB] FAIL rand_retire[%0d] op %0d: got lat %0d ill %b expected %0d %b", k, op, lat, ill, exp_lat, exp_ill); else pass_cnt++;
      total_cnt++; if (dbg_data !== m_gpr[rd]) $display("[TB] FAIL rand_value[%0d] op %0d: got %h expected %h", k, op, dbg_data, m_gpr[rd]); else pass_cnt++;
      total_cnt++; if (flags !== m_flags) $display("[TB] FAIL rand_flags[%0d] op %0d: got %b expected %b", k, op, flags, m_flags); else pass_cnt++;
      total_cnt++; if (sgpr !== m_sgpr) $display("[TB] FAIL rand_sgpr[%0d] op %0d: got %h expected %h", k, op, sgpr, m_sgpr); else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    dbg_addr = '0;
    model_reset();
    test_reset();
    test_back_to_back();
    test_add_flags();
    test_mul();
    test_mul_hold();
    test_illegal();
    test_reset_during_mul();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
